// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port RGB332 frame buffer between VGA fetch and a FIFO-buffered pixel writer.
// Optional stall counter is built when VGA_ARB_STALL_CNT_EN is defined.
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        pxclk,
    input  logic                        rst_n,
    input  logic                        Display,
    input  logic [9:0]                  Column,
    input  logic [9:0]                  Row,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [7:0]                  wr_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [7:0]                  mem_wdata,
    input  logic [7:0]                  mem_rdata,
    output logic [7:0]                  red,
    output logic [7:0]                  green,
    output logic [7:0]                  blue,
    output logic                        pix_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 frame_cnt,
    output logic                        addr_err,
    output logic [15:0]                 stall_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PIX_END = ADDR_W'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [7:0]        q_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              empty, push, pop, head_ok, disp_d2;
    logic [ADDR_W-1:0] disp_addr;

    // wr_ready is gated by rst_n so every output reads 0 while reset is held
    assign empty     = fifo_level == '0;
    assign wr_ready  = rst_n && fifo_level != (PW+1)'(FIFO_DEPTH);
    assign push      = wr_valid && wr_ready;
    assign pop       = !Display && !empty;
    assign head_ok   = q_addr[rd_ptr] < PIX_END;
    assign disp_addr = ADDR_W'(Row) * ADDR_W'(H_ACTIVE) + ADDR_W'(Column);

    always_ff @(posedge pxclk)
        if (push) begin
            q_addr[wr_ptr] <= wr_addr;
            q_data[wr_ptr] <= wr_data;
        end

    always_ff @(posedge pxclk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            addr_err   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            frame_cnt  <= '0;
            disp_d2    <= 1'b0;
            pix_valid  <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
            if (Display) begin
                state    <= S_DISP;
                mem_addr <= disp_addr;
                mem_we   <= 1'b0;
            end else if (!empty) begin
                state  <= S_WRITE;
                mem_we <= head_ok;
                if (head_ok) begin
                    mem_addr  <= q_addr[rd_ptr];
                    mem_wdata <= q_data[rd_ptr];
                end else
                    addr_err <= 1'b1;
            end else begin
                state  <= S_IDLE;
                mem_we <= 1'b0;
            end
            if (Display && Row == '0 && Column == '0)
                frame_cnt <= frame_cnt + 16'd1;
            // S_DISP marks the cycle the fetch address is on the bus; two more stages reach the DAC
            disp_d2   <= state == S_DISP;
            pix_valid <= disp_d2;
            red       <= disp_d2 ? {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]} : '0;
            green     <= disp_d2 ? {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]} : '0;
            blue      <= disp_d2 ? {4{mem_rdata[1:0]}} : '0;
        end

`ifdef VGA_ARB_STALL_CNT_EN
    always_ff @(posedge pxclk or negedge rst_n)
        if (!rst_n)
            stall_cnt <= '0;
        else if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized and directed checks of vga_fb_arbiter against a queue-based reference model.
// Honours VGA_ARB_STALL_CNT_EN to pick the expected stall_cnt behaviour.
module tb_vga_fb_arbiter;
    localparam int H = 640;
    localparam int PIX_END = 640 * 480;
    localparam int DEPTH = 4;
`ifdef VGA_ARB_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        pxclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Display = 1'b0;
    logic [9:0]  Column = '0, Row = '0;
    logic        wr_valid = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  mem_rdata;
    logic        wr_ready, mem_we, pix_valid, addr_err;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata, red, green, blue;
    logic [2:0]  fifo_level;
    logic [15:0] frame_cnt, stall_cnt;

    always #5 pxclk = ~pxclk;

    vga_fb_arbiter dut (
        .pxclk(pxclk), .rst_n(rst_n), .Display(Display), .Column(Column), .Row(Row),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid),
        .fifo_level(fifo_level), .frame_cnt(frame_cnt), .addr_err(addr_err), .stall_cnt(stall_cnt)
    );

    // frame-buffer memory: synchronous read, preloaded with a known pattern on the first edge
    logic [7:0] fb [4096];
    logic       fb_init = 1'b0;
    always @(posedge pxclk) begin
        if (!fb_init) begin
            for (int i = 0; i < 4096; i++) fb[i] <= 8'(i * 37 + 5);
            fb_init <= 1'b1;
        end else if (mem_we)
            fb[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= fb[mem_addr[11:0]];
    end

    typedef struct {int addr; logic [7:0] data;} wr_t;
    wr_t         q[$];
    logic [7:0]  gold [4096];
    int          n_chk = 0, n_fail = 0;
    logic        m_we, m_err, pend;
    int          m_addr, pend_addr;
    logic [7:0]  m_wdata, pend_data;
    logic [15:0] m_frame, m_stall;
    logic [24:0] p0, p1, m_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb(input logic [7:0] p);
        int r = int'(p) / 32;
        int g = (int'(p) / 4) % 8;
        int b = int'(p) % 4;
        return {8'(r * 32 + r * 4 + r / 2), 8'(g * 32 + g * 4 + g / 2), 8'(b * 85)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0; m_frame = 0; m_stall = 0;
        p0 = 0; p1 = 0; m_pix = 0; pend = 0;
    endtask

    task automatic model_edge();
        bit  ready = q.size() < DEPTH;
        int  a;
        wr_t h;
        if (pend) gold[pend_addr] = pend_data;
        pend = 0;
        if (STALL_EN && wr_valid && !ready && m_stall != 16'hFFFF) m_stall++;
        if (Display && Row == 0 && Column == 0) m_frame++;
        m_pix = p1;
        p1 = p0;
        m_we = 0;
        if (Display) begin
            a = Row * H + Column;
            p0 = {1'b1, rgb(gold[a])};
            m_addr = a;
        end else begin
            p0 = '0;
            if (q.size() > 0) begin
                h = q.pop_front();
                if (h.addr < PIX_END) begin
                    m_we = 1; m_addr = h.addr; m_wdata = h.data;
                    pend = 1; pend_addr = h.addr; pend_data = h.data;
                end else
                    m_err = 1;
            end
        end
        if (wr_valid && ready) q.push_back('{int'(wr_addr), wr_data});
    endtask

    task automatic check_all();
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("fifo_level", fifo_level, q.size());
        check("wr_ready", wr_ready, q.size() < DEPTH);
        check("pixel", {pix_valid, red, green, blue}, m_pix);
        check("addr_err", addr_err, m_err);
        check("frame_cnt", frame_cnt, m_frame);
        check("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic step();
        @(posedge pxclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic d, input int r, input int c, input logic v, input int a, input logic [7:0] dat);
        Display = d; Row = 10'(r); Column = 10'(c); wr_valid = v; wr_addr = 19'(a); wr_data = dat;
    endtask

    initial begin
        logic disp = 1'b0;
        int   ad;
        for (int i = 0; i < 4096; i++) gold[i] = 8'(i * 37 + 5);
        model_reset();
        #3;
        check("rst_we", mem_we, 0);
        check("rst_ready", wr_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_pix", {pix_valid, red, green, blue}, 0);
        @(negedge pxclk);
        rst_n = 1'b1;
        // place 0xE3 at row 2 col 5 through the writer, then fetch it
        drive(0, 0, 0, 1, 1285, 8'hE3); step();
        drive(0, 0, 0, 0, 0, 0); step();
        check("preload_we", mem_we, 1);
        check("preload_addr", mem_addr, 1285);
        step();
        drive(1, 2, 5, 0, 0, 0); step();
        check("rd_addr", mem_addr, 1285);
        drive(0, 0, 0, 0, 0, 0); step(); step();
        check("rd_rgb", {pix_valid, red, green, blue}, {1'b1, 24'hFF00FF});
        step();
        check("rd_done", pix_valid, 0);
        // writes held during active video, then drained in order
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, i, 1, 100 + i, 8'(16 + i)); step();
            if (i == 3) check("full_ready", wr_ready, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_we", mem_we, 1);
            check("drain_addr", mem_addr, 100 + i);
            check("drain_level", fifo_level, 3 - i);
        end
        step();
        check("drain_idle", mem_we, 0);
        // out-of-range write is dropped
        drive(0, 0, 0, 1, PIX_END, 8'h55); step();
        drive(0, 0, 0, 0, 0, 0); step();
        check("oor_err", addr_err, 1);
        check("oor_we", mem_we, 0);
        step(); step();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) disp = !disp;
            ad = ($urandom_range(0, 15) == 0) ? PIX_END + int'($urandom_range(0, 200000))
                                             : int'($urandom_range(0, 3)) * H + int'($urandom_range(0, 15));
            drive(disp, $urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)), ad, 8'($urandom));
            step();
        end
        check("err_sticky", addr_err, 1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();
        // reset in the middle of a write with entries still queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i, 1, 200 + i, 8'(i + 1)); step();
        end
        drive(0, 0, 0, 0, 0, 0); step();
        check("pre_rst_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_we_async", mem_we, 0);
        check("rst_level_async", fifo_level, 0);
        model_reset();
        @(negedge pxclk);
        rst_n = 1'b1;
        repeat (5) begin
            step();
            check("rst_no_write", mem_we, 0);
        end
        check("rst_err_clear", addr_err, 0);
        // full FIFO during active video with the writer still asking
        for (int i = 0; i < 14; i++) begin
            drive(1, 3, i, 1, 300 + i, 8'(i)); step();
        end
        check("stall", stall_cnt, STALL_EN ? 10 : 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();
        // frame counter wrap
        drive(1, 0, 0, 0, 0, 0);
        while (m_frame != 16'hFFFF) step();
        check("frame_ffff", frame_cnt, 16'hFFFF);
        step();
        check("frame_wrap", frame_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port RGB332 frame-buffer memory between two users: the VGA display fetch, driven by the timing generator's Display/Column/Row, and a pixel writer, such as a drawing engine or CPU bridge.
- The display always owns the port during active video.
- Writer requests are buffered in a small FIFO and drained only while Display is low.
- Expands the fetched RGB332 pixel to 8-bit red/green/blue for the VGA DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line; used in address computation.
- V_ACTIVE, 480, visible lines per frame; used for the write address range check.
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- FIFO_DEPTH, 4, writer FIFO entries; must be a power of 2, minimum 2.

Ports:
- pxclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Display  in  1  active-video flag from the timing generator.
- Column  in  10  current pixel column, valid when Display=1.
- Row  in  10  current pixel row, valid when Display=1.
- wr_valid  in  1  writer request valid.
- wr_ready  out  1  FIFO can accept; high when FIFO not full.
- wr_addr  in  ADDR_W  linear pixel address, row*H_ACTIVE+col.
- wr_data  in  8  RGB332 pixel.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_we  out  1  memory write enable, registered.
- mem_wdata  out  8  memory write data, registered.
- mem_rdata  in  8  read data; synchronous, 1-cycle latency after mem_addr.
- red  out  8  expanded red.
- green  out  8  expanded green.
- blue  out  8  expanded blue.
- pix_valid  out  1  red/green/blue correspond to an active pixel.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_cnt  out  16  frames started; wraps.
- addr_err  out  1  sticky flag: an out-of-range write was dropped.
- stall_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): all of the following are 0 immediately: every output, FIFO pointers, pipeline registers, state (S_IDLE). Any queued writes are discarded; a reset during a write aborts it, with mem_we forced low asynchronously.
- Port owner FSM, evaluated every cycle from the current inputs; the next state is registered:
  - Display=1 -> S_DISP: mem_addr <= Row*H_ACTIVE+Column, mem_we <= 0.
  - Display=0 and FIFO not empty -> S_WRITE: pop the head entry.
    - Head addr < H_ACTIVE*V_ACTIVE: mem_addr <= addr, mem_wdata <= data, mem_we <= 1.
    - Otherwise: mem_we <= 0 and addr_err <= 1.
  - Otherwise -> S_IDLE: mem_we <= 0; mem_addr and mem_wdata hold.
  - Display has absolute priority; a write is never issued in a slot where Display=1 was sampled. There is exactly one memory operation per cycle.
- Address arithmetic: Row*H_ACTIVE+Column computed at ADDR_W bits with no truncation for in-range Row/Column.
- Display pipeline, latency 3 cycles:
  - Display sampled in cycle N -> mem_addr valid in N+1 -> mem_rdata valid in N+2 -> red/green/blue/pix_valid registered in N+3.
  - pix_valid is Display delayed by 3.
  - When the delayed Display=0: red=green=blue=0.
- RGB332 expansion, with p = pixel byte:
  - red = {p[7:5],p[7:5],p[7:6]}
  - green = {p[4:2],p[4:2],p[4:3]}
  - blue = {p[1:0],p[1:0],p[1:0],p[1:0]}
- Writer FIFO:
  - Push when wr_valid & wr_ready.
  - wr_ready = !full; it is not raised by a same-cycle pop.
  - Simultaneous push and pop leaves the level unchanged.
  - Order is preserved; pointers wrap modulo FIFO_DEPTH.
  - A full FIFO during active video holds wr_ready low until blanking drains an entry.
- frame_cnt increments in the cycle Display=1 with Row==0 and Column==0; it wraps 0xFFFF->0.
- addr_err is cleared only by reset.

Optional Feature:
- Macro: VGA_ARB_STALL_CNT_EN.
- Defined: stall_cnt counts cycles with wr_valid=1 and wr_ready=0. It saturates at 0xFFFF and resets to 0.
- Undefined: stall_cnt is tied to 0 and no counter logic is built. The port exists in both builds.

Test Plan:
- Reset mid-write:
  - Stimulus: rst_n low during a cycle with mem_we=1, with 3 entries queued.
  - Response: mem_we=0 immediately; fifo_level=0 after release; the queued entries are never written.
- Display read path:
  - Stimulus: Display=1, Row=2, Column=5, H_ACTIVE=640; model memory returns 0xE3.
  - Response: mem_addr=1285 one cycle later. Three cycles after the sample: red=0xFF, green=0x00, blue=0xFF, pix_valid=1.
- Writes held during active video:
  - Stimulus: 4 writes pushed while Display=1, then a 5th write attempted.
  - Response: mem_we stays 0 throughout; wr_ready=0 after the 4th push. Writes are issued in push order starting the first cycle after Display falls, one per cycle, with fifo_level counting down 4->0.
- Out-of-range write:
  - Stimulus: wr_addr=307200 pushed in blanking.
  - Response: no mem_we pulse; addr_err=1 and stays 1 until reset.
- Frame counter wrap:
  - Stimulus: frame_cnt forced to 0xFFFF, then a Display cycle with Row=0, Column=0.
  - Response: frame_cnt=0x0000.
- Stall counter:
  - Stimulus: VGA_ARB_STALL_CNT_EN defined; FIFO full; wr_valid held high for 10 active cycles.
  - Response: stall_cnt=10. With the macro undefined, stall_cnt=0.
